// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG SRAM loader: state encoding, default
// widths and the number of pixel bytes packed into one SRAM word.
package jpeg_pkg;

  localparam int unsigned ADDR_W_DEF     = 15;
  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned BYTES_PER_WORD = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/jpeg_mem_loader_if.sv
// Pixel byte stream in, SRAM write port out.
// master: byte source / SRAM side (testbench); slave: the loader itself.
interface jpeg_mem_loader_if
  import jpeg_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              nwrt;
  logic              nce;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-5:0] ra;
  logic [3:0]        ca;

  modport master (
    output in_data, in_valid,
    input  in_ready, nwrt, nce, din, ra, ca
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, nwrt, nce, din, ra, ca
  );

endinterface

// File: rtl/jpeg_byte_packer.sv
// Collects pixel bytes MSB-first into one SRAM word. 'last' flags the
// accept that completes a word; the counter wraps to 0 on that byte.
module jpeg_byte_packer
  import jpeg_pkg::*;
#(
  parameter int unsigned BYTES = BYTES_PER_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         data,
  output logic [BYTES*8-1:0] word,
  output logic               last
);

  localparam int unsigned CNT_W = $clog2(BYTES);

  logic [CNT_W-1:0] count;

  assign last = accept && (count == CNT_W'(BYTES - 1));

  // Shift each accepted byte in at the bottom so byte 0 ends up on top.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
      word  <= '0;
    end else if (accept) begin
      word  <= {word[BYTES*8-9:0], data};
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/jpeg_mem_loader.sv
// Loads num_words SRAM words starting at base_addr from a pixel byte stream.
// Optional feature macro: LOADER_CHECKSUM_EN adds a 16-bit byte-sum output.
module jpeg_mem_loader
  import jpeg_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_words,
  output logic              busy,
  output logic              done,
`ifdef LOADER_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  jpeg_mem_loader_if.slave  bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       remaining;
  logic [DATA_W-1:0] word;
  logic              last;
  logic              accept;
  logic              start_ok;
  logic              busy_d;
  logic              done_d;

  assign start_ok = (state == IDLE) && start;
  assign accept   = bus.in_valid && bus.in_ready;

  jpeg_byte_packer #(
    .BYTES (DATA_W / 8)
  ) u_packer (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .accept (accept),
    .data   (bus.in_data),
    .word   (word),
    .last   (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (num_words == 16'd0) ? FINISH : FILL;
      FILL:    if (last) state_nxt = WRITE;
      WRITE:   state_nxt = (remaining == 16'd1) ? FINISH : FILL;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: SRAM strobes decode straight from state; busy/done are
  // computed here and registered so done lands the cycle after FINISH.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.nwrt     = 1'b1;
    bus.nce      = 1'b1;
    bus.din      = '0;
    bus.ra       = addr[ADDR_W-1:4];
    bus.ca       = addr[3:0];
    busy_d       = 1'b0;
    done_d       = 1'b0;
    unique case (state)
      IDLE:    busy_d = start;
      FILL: begin
        bus.in_ready = 1'b1;
        busy_d       = 1'b1;
      end
      WRITE: begin
        bus.nwrt = 1'b0;
        bus.nce  = 1'b0;
        bus.din  = word;
        busy_d   = 1'b1;
      end
      FINISH:  done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Address and word counters: loaded on start, stepped after each write.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (start_ok) begin
      addr      <= base_addr;
      remaining <= num_words;
    end else if (state == WRITE) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 16'd1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of accepted bytes since the last accepted start.
  always_ff @(posedge clk) begin
    if (reset || start_ok) checksum <= '0;
    else if (accept)       checksum <= checksum + 16'(bus.in_data);
  end
`endif

endmodule

// File: tb/tb_jpeg_mem_loader.sv
// Directed bench for jpeg_mem_loader with a write scoreboard.
module tb_jpeg_mem_loader;

  typedef struct packed {
    logic [14:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] num_words;
  logic        busy;
  logic        done;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int wr_count  = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int st_cyc    = 0;
  wr_t exp_q[$];
  int  wr_cyc_q[$];

  jpeg_mem_loader_if #(.ADDR_W(15), .DATA_W(64)) bus ();

  jpeg_mem_loader #(.ADDR_W(15), .DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
`ifdef LOADER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor and done tracker, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.nwrt === 1'b0) begin
      wr_t e;
      wr_count++;
      wr_cyc_q.push_back(cyc);
      chk("wr_nce", 64'(bus.nce), 64'd0);
      chk("wr_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'({bus.ra, bus.ca}), 64'(e.addr));
        chk("wr_data", bus.din, e.data);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 64'(busy), 64'd0);
    end
  end

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_nwrt", 64'(bus.nwrt), 64'd1);
    chk("rst_nce", 64'(bus.nce), 64'd1);
    chk("rst_din", bus.din, 64'd0);
    chk("rst_ra_ca", 64'({bus.ra, bus.ca}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
  endtask

  task automatic do_start(input logic [14:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n;
    st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 4; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("byte_accept_timeout", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic send_word(input logic [14:0] a, input logic [63:0] w, input bit gaps);
    exp_q.push_back('{addr: a, data: w});
    for (int k = 0; k < 8; k++) send_byte(w[63-8*k -: 8], gaps);
  endtask

  task automatic wait_done(input int prev);
    for (int t = 0; t < 400; t++) begin
      if (done_cnt > prev) return;
      @(negedge clk);
    end
    chk("done_timeout", 64'(done_cnt), 64'(prev + 1));
  endtask

  initial begin
    int d0;
    int w0;
    logic [63:0] w;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    bus.in_data = '0; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;

    // Single word, back-to-back bytes.
    d0 = done_cnt; w0 = wr_count;
    do_start(15'h0010, 16'd1);
    chk("busy_after_start", 64'(busy), 64'd1);
    send_word(15'h0010, 64'h0102030405060708, 1'b0);
    bus.in_valid = 1'b0;
    wait_done(d0);
    chk("one_write", 64'(wr_count - w0), 64'd1);
    chk("done_after_write", 64'(done_cyc - wr_cyc_q[wr_cyc_q.size()-1]), 64'd2);

    // Three words, continuous stream: writes 9 cycles apart.
    d0 = done_cnt; w0 = wr_count;
    do_start(15'h0010, 16'd3);
    for (int i = 0; i < 3; i++) begin
      w = {$urandom, $urandom};
      send_word(15'(16'h0010 + i), w, 1'b0);
    end
    bus.in_valid = 1'b0;
    wait_done(d0);
    chk("three_writes", 64'(wr_count - w0), 64'd3);
    chk("spacing_1", 64'(wr_cyc_q[wr_cyc_q.size()-2] - wr_cyc_q[wr_cyc_q.size()-3]), 64'd9);
    chk("spacing_2", 64'(wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[wr_cyc_q.size()-2]), 64'd9);

    // Address wrap at the top of the SRAM.
    d0 = done_cnt;
    do_start(15'h7FFF, 16'd2);
    send_word(15'h7FFF, 64'hA1A2A3A4A5A6A7A8, 1'b0);
    send_word(15'h0000, 64'hB1B2B3B4B5B6B7B8, 1'b0);
    bus.in_valid = 1'b0;
    wait_done(d0);

    // Random in_valid gaps, with a stray start pulse while busy.
    d0 = done_cnt; w0 = wr_count;
    do_start(15'h0200, 16'd4);
    for (int i = 0; i < 4; i++) begin
      w = {$urandom, $urandom};
      exp_q.push_back('{addr: 15'(16'h0200 + i), data: w});
      for (int k = 0; k < 8; k++) begin
        send_byte(w[63-8*k -: 8], 1'b1);
        if (i == 1 && k == 4) begin
          bus.in_valid = 1'b0;
          start = 1'b1; base_addr = 15'h0100; num_words = 16'd9;
          @(posedge clk); #1;
          start = 1'b0;
          chk("busy_hold", 64'(busy), 64'd1);
        end
      end
    end
    bus.in_valid = 1'b0;
    wait_done(d0);
    chk("four_writes", 64'(wr_count - w0), 64'd4);

    // Reset after 5 bytes of word 2: that word must never be written.
    w0 = wr_count;
    do_start(15'h0020, 16'd3);
    send_word(15'h0020, 64'h1112131415161718, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h21 + k), 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_partial_write", 64'(wr_count - w0), 64'd1);
    chk("sb_drained_rst", 64'(exp_q.size()), 64'd0);
    d0 = done_cnt;
    do_start(15'h0040, 16'd1);
    send_word(15'h0040, 64'hC1C2C3C4C5C6C7C8, 1'b0);
    bus.in_valid = 1'b0;
    wait_done(d0);

`ifdef LOADER_CHECKSUM_EN
    d0 = done_cnt;
    do_start(15'h0300, 16'd2);
    send_word(15'h0300, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send_word(15'h0301, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    bus.in_valid = 1'b0;
    wait_done(d0);
    chk("checksum_ff", 64'(checksum), 64'h0FF0);
`endif

    // Zero-length load: done two cycles after start, no write.
    d0 = done_cnt; w0 = wr_count;
    do_start(15'h0055, 16'd0);
    wait_done(d0);
    chk("zero_done_latency", 64'(done_cyc - st_cyc), 64'd2);
    chk("zero_no_write", 64'(wr_count - w0), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum_zero", 64'(checksum), 64'd0);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jpeg_mem_loader.md
JPEG_MEM_LOADER -- requirements
Module: jpeg_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 64, SRAM word width (8 pixels x 8 bits).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a load.
REQ-006 SHALL have port base_addr, input, ADDR_W, first word address, captured on accepted start.
REQ-007 SHALL have port num_words, input, 16, words to load, captured on accepted start.
REQ-008 SHALL have port in_data, input, 8, pixel byte.
REQ-009 SHALL have port in_valid, input, 1, in_data valid.
REQ-010 SHALL have port in_ready, output, 1, loader accepts a byte this cycle.
REQ-011 SHALL have port nwrt, output, 1, active-low SRAM write strobe.
REQ-012 SHALL have port nce, output, 1, active-low SRAM chip enable.
REQ-013 SHALL have port din, output, DATA_W, SRAM write data.
REQ-014 SHALL have port ra, output, ADDR_W-4, SRAM row address (word address [ADDR_W-1:4]).
REQ-015 SHALL have port ca, output, 4, SRAM column address (word address [3:0]).
REQ-016 SHALL have port busy, output, 1, high from accepted start until done.
REQ-017 SHALL have port done, output, 1, one-cycle pulse when the last word is written.

Function
REQ-018 SHALL implement states IDLE, FILL, WRITE, FINISH.
REQ-019 SHALL, in IDLE, accept start; start with num_words=0 goes to FINISH, otherwise to FILL.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL drive in_ready=1 only in FILL; a byte is consumed when in_valid && in_ready.
REQ-022 SHALL pack bytes MSB-first: byte k of a word (k=0..7) lands in din[63-8k:56-8k].
REQ-023 SHALL count accepted bytes 0..7; on the 8th accepted byte, transition to WRITE next cycle.
REQ-024 SHALL, in WRITE, drive nwrt=0, nce=0, din=packed word, {ra,ca}=current address for exactly one cycle.
REQ-025 SHALL keep nwrt=1 and nce=1 in every other state.
REQ-026 SHALL increment the address after each WRITE, wrapping from 2^ADDR_W-1 to 0.
REQ-027 SHALL decrement the remaining-word count after each WRITE; at zero go to FINISH, else back to FILL.
REQ-028 SHALL, in FINISH, pulse done=1 for one cycle and return to IDLE; busy drops in the same cycle.
REQ-029 SHALL achieve steady throughput of one word per 9 cycles with in_valid held high (8 FILL + 1 WRITE).
REQ-030 SHALL tolerate in_valid gaps in FILL with no byte loss or duplication.

Reset
REQ-031 SHALL, on reset, force IDLE, in_ready=0, nwrt=1, nce=1, din=0, ra=0, ca=0, busy=0, done=0, and clear byte and word counters.
REQ-032 SHALL, on reset mid-load, abandon the load with no further SRAM write; a partial word is discarded.

Configuration
REQ-033 SHALL, with LOADER_CHECKSUM_EN defined, add output checksum (16 bits): a modulo-2^16 sum of all bytes accepted since the last accepted start, cleared on start and reset, stable after done.
REQ-034 SHALL, without LOADER_CHECKSUM_EN, omit the checksum port and logic entirely.

Structure
REQ-035 SHALL place the state encoding typedef, ADDR_W/DATA_W defaults and the byte count per word (8) in shared package jpeg_pkg.
REQ-036 SHALL keep the byte packer (shift register plus 0..7 counter) as sub-module jpeg_byte_packer; all other logic stays in jpeg_mem_loader.

Verification
REQ-037 SHALL cover this case: start, base_addr=0x0010, num_words=1, bytes 0x01..0x08 back-to-back -> one write cycle with din=0x0102030405060708 and ra=0x001, ca=0x0; done pulses 2 cycles later.
REQ-038 SHALL cover this case: num_words=3 with continuous in_valid -> writes at 0x0010/0x0011/0x0012, 9 cycles apart, exactly 3 nwrt=0 cycles.
REQ-039 SHALL cover this case: base_addr=0x7FFF, num_words=2 -> writes at 0x7FFF then 0x0000 (ra=0x000, ca=0x0).
REQ-040 SHALL cover this case: in_valid toggled randomly with 50% duty, 4 words -> SRAM contents match the byte stream exactly; a start pulse while busy has no effect.
REQ-041 SHALL cover this case: reset asserted after 5 bytes of word 2 -> no write for word 2; all outputs at reset values; a new start loads from the new base_addr.
REQ-042 SHALL cover this case: with LOADER_CHECKSUM_EN, bytes 0xFF x 16 (2 words) -> checksum=0x0FF0 at done; num_words=0 -> done pulses 2 cycles after start, with no write and checksum=0.
